sseg_scan_mux: RTL
==================

// Module: sseg_scan_mux
// PURPOSE
//  Parametrised N-digit seven-segment scan multiplexer with built-in hex decode.
//  Sits between datapath logic and the board SSEG_CA/SSEG_AN pins.
//  Adds per-digit enable, decimal points, PWM brightness, a programmable anti-ghost
//  blanking window, and a tear-free shadow-register update handshake.
// PARAMETERS
//  NUM_DIGITS   8    digits scanned; digit 0 = rightmost = SSEG_AN[0]
//  CLK_DIV      2500 CLK cycles per scan tick; must be >=1
//  SLOT_TICKS   16   ticks per digit slot
//  BLANK_TICKS  2    leading ticks of each slot with all anodes off; <SLOT_TICKS
//  (localparam) BRIGHT_W = $clog2(SLOT_TICKS)+1
// PORTS
//  CLK          in   1             system clock
//  RST_N        in   1             async active-low reset
//  hex_in       in   4*NUM_DIGITS  digit values; nibble k = digit k
//  dp_in        in   NUM_DIGITS    1 = light decimal point of digit k
//  en_in        in   NUM_DIGITS    1 = digit k enabled
//  bright_in    in   BRIGHT_W      on-ticks per slot; 0 = dark
//  lz_en        in   1             leading-zero blanking request (see CONFIGURATION)
//  upd_req      in   1             request to load inputs into shadow registers
//  upd_ack      out  1             1-cycle pulse: inputs captured this cycle
//  frame_start  out  1             1-cycle pulse at each frame boundary
//  SSEG_CA      out  8             cathodes, active low, {dp,g,f,e,d,c,b,a}
//  SSEG_AN      out  NUM_DIGITS    anodes, active low
// BEHAVIOUR
//  Reset (async): SSEG_CA=8'hFF, SSEG_AN=all 1, upd_ack=0, frame_start=0.
//    Counters=0. Shadow hex/dp/en/bright=0, so the display is dark until the first update.
//  Tick: prescaler counts 0..CLK_DIV-1. tick=1 on the count CLK_DIV-1, then wraps.
//  Phase counter p=0..SLOT_TICKS-1 advances per tick. Digit index d advances when p wraps.
//    d wraps NUM_DIGITS-1 -> 0. Frame = NUM_DIGITS*SLOT_TICKS*CLK_DIV clocks.
//  Frame boundary: the cycle where tick=1 with d=NUM_DIGITS-1 and p=SLOT_TICKS-1.
//    frame_start pulses in this cycle.
//    If upd_req=1 in this cycle: shadow<=inputs and upd_ack pulses in the same cycle.
//    upd_req low at the boundary: nothing is captured.
//    upd_req held high: an ack is issued at every boundary.
//    No frame_start pulse for the partial frame after reset; the first pulse comes one full frame after release.
//  Displayed values change only at a frame boundary, never mid-frame.
//  Slot d, output registers (all outputs registered, 1-cycle latency from counters):
//    p<BLANK_TICKS: SSEG_AN=all 1. SSEG_CA <= decode(shadow digit d) during the blank window.
//    p>=BLANK_TICKS: AN[d]=0 iff en[d] && (p-BLANK_TICKS)<bright. Otherwise all 1.
//    bright >= SLOT_TICKS-BLANK_TICKS clamps to the full on-window.
//    Disabled digit: SSEG_CA=8'hFF and AN all 1 for the whole slot; the slot still consumes its time.
//  Decode: standard hex 0-F, active low, e.g. 0=8'hC0, 1=8'hF9, 7=8'hF8, A=8'h88, F=8'h8E.
//    bit7 = ~dp.
//  At most one anode is low at any time. The anode is never low in a cycle where SSEG_CA changes.
//  Reset mid-frame: outputs go dark immediately, the frame restarts at d=0, p=0, and a pending request is dropped.
// CONFIGURATION
//  Macro SSEG_LZ_BLANK_EN:
//    Defined: when shadow lz_en=1, digits above the highest nonzero digit are blanked.
//      Blanked digits behave as disabled.
//      Digit 0 is never blanked.
//      A digit with dp=1 is never blanked and also stops blanking of lower digits.
//      lz_en is captured into the shadow like the other inputs.
//    Undefined: the lz_en port exists but is ignored; no blanking logic is synthesised.
// TESTING  (NUM_DIGITS=4, CLK_DIV=4, SLOT_TICKS=8, BLANK_TICKS=2, frame=128 clk)
//  1 Reset: RST_N=0 mid-slot -> SSEG_CA=FF and SSEG_AN=F with no clock edge.
//    Release -> first frame_start 128 clk later; no upd_ack without upd_req.
//  2 Update: hex=16'h000A, dp=0, en=F, bright=6, upd_req held -> upd_ack at boundary.
//    Next frame, digit 0: AN=4'b1110 for 24 clk after 8 blank clk; CA=88.
//    Digits 1-3 show CA=C0.
//  3 Brightness: bright=0 -> AN stays F all frame. bright=15 -> each digit low 24 clk per slot, same as bright=6.
//  4 Tear-free: change hex_in mid-frame with upd_req=0 -> display unchanged.
//    Raise upd_req mid-frame -> new values appear only after the next frame_start, with exactly 1 ack pulse per boundary.
//  5 Enable/dp: en=4'b0101, dp=4'b0001 -> AN[1] and AN[3] never low; slot timing is unchanged.
//    Digit 0 CA bit7=0.
//  6 LZ: hex=16'h0070, lz_en=1 -> with macro: digits 3,2 dark, digit 1 CA=F8, digit 0 CA=C0.
//    Without macro: digits 3,2 show C0.

Source files
------------

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - N-digit seven-segment scan mux with hex decode, PWM and shadow update; option macro SSEG_LZ_BLANK_EN
`timescale 1ns/1ps
module sseg_scan_mux #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int CLK_DIV     = 2500,
  parameter  int SLOT_TICKS  = 16,
  parameter  int BLANK_TICKS = 2,
  localparam int BRIGHT_W    = $clog2(SLOT_TICKS) + 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic [BRIGHT_W-1:0]     bright_in,
  input  logic                    lz_en,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic                    frame_start,
  output logic [7:0]              SSEG_CA,
  output logic [NUM_DIGITS-1:0]   SSEG_AN
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(SLOT_TICKS - 1);
  localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BLANK_V  = BRIGHT_W'(BLANK_TICKS);

  logic [DIV_W-1:0]        r_presc;
  logic [PH_W-1:0]         r_phase;
  logic [DIG_W-1:0]        r_digit;
  logic [4*NUM_DIGITS-1:0] r_sh_hex;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic [BRIGHT_W-1:0]     r_sh_bright;
  logic [7:0]              r_ca;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tick;
  logic                    w_boundary;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic [3:0]              w_dig_hex;
  logic                    w_dig_dp;
  logic                    w_dig_vis;
  logic [BRIGHT_W-1:0]     w_phase_ext;
  logic                    w_in_window;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble
  function automatic logic [6:0] f_seg(input logic [3:0] i_v);
    case (i_v)
      4'h0: f_seg = 7'h40;
      4'h1: f_seg = 7'h79;
      4'h2: f_seg = 7'h24;
      4'h3: f_seg = 7'h30;
      4'h4: f_seg = 7'h19;
      4'h5: f_seg = 7'h12;
      4'h6: f_seg = 7'h02;
      4'h7: f_seg = 7'h78;
      4'h8: f_seg = 7'h00;
      4'h9: f_seg = 7'h10;
      4'hA: f_seg = 7'h08;
      4'hB: f_seg = 7'h03;
      4'hC: f_seg = 7'h46;
      4'hD: f_seg = 7'h21;
      4'hE: f_seg = 7'h06;
      default: f_seg = 7'h0E;
    endcase
  endfunction

  assign w_tick      = (r_presc == DIV_LAST);
  assign w_boundary  = w_tick && (r_phase == PH_LAST) && (r_digit == DIG_LAST);
  // Handshake pulses sit in the boundary cycle itself, so the ack lines up with the capturing edge
  assign frame_start = w_boundary;
  assign upd_ack     = w_boundary && upd_req;

  // Prescaler, slot phase and digit index; one frame is a full sweep of all three
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
      r_phase <= '0;
      r_digit <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_phase == PH_LAST) begin
        r_phase <= '0;
        r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Shadow registers load only at the frame boundary so a frame never tears
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sh_hex    <= '0;
      r_sh_dp     <= '0;
      r_sh_en     <= '0;
      r_sh_bright <= '0;
    end else if (w_boundary && upd_req) begin
      r_sh_hex    <= hex_in;
      r_sh_dp     <= dp_in;
      r_sh_en     <= en_in;
      r_sh_bright <= bright_in;
    end
  end

`ifdef SSEG_LZ_BLANK_EN
  logic r_sh_lz;
  logic w_lz_run;

  // Shadow copy of the leading-zero request, loaded alongside the other inputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sh_lz <= 1'b0;
    end else if (w_boundary && upd_req) begin
      r_sh_lz <= lz_en;
    end
  end

  // Blank zero digits from the top down until a nonzero digit or a lit dp; digit 0 always shows
  always_comb begin
    w_lz_blank = '0;
    w_lz_run   = r_sh_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (w_lz_run && (r_sh_hex[4*k +: 4] == 4'h0) && !r_sh_dp[k]) begin
        w_lz_blank[k] = 1'b1;
      end else begin
        w_lz_run = 1'b0;
      end
    end
  end
`else
  logic w_unused_lz;
  assign w_unused_lz = lz_en;
  assign w_lz_blank  = '0;
`endif

  assign w_dig_hex   = r_sh_hex[{r_digit, 2'b00} +: 4];
  assign w_dig_dp    = r_sh_dp[r_digit];
  assign w_dig_vis   = r_sh_en[r_digit] && !w_lz_blank[r_digit];
  assign w_phase_ext = BRIGHT_W'(r_phase);
  // Brightness above the on-window length saturates naturally: every on-tick satisfies the compare
  assign w_in_window = (w_phase_ext >= BLANK_V) && ((w_phase_ext - BLANK_V) < r_sh_bright);

  // Registered pins; cathodes settle during the blank window before any anode is driven
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ca <= 8'hFF;
      r_an <= '1;
    end else begin
      r_an <= '1;
      if (w_dig_vis) begin
        r_ca <= {~w_dig_dp, f_seg(w_dig_hex)};
        if (w_in_window) begin
          r_an[r_digit] <= 1'b0;
        end
      end else begin
        r_ca <= 8'hFF;
      end
    end
  end

  assign SSEG_CA = r_ca;
  assign SSEG_AN = r_an;

endmodule
